mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM for the MIPS core. It sequences a datapath that shares one single-port
//  memory for instruction fetch and data access, using a req/ready handshake.
//  Per instruction it drives PC, IR, register-file, ALU-mux and memory controls.
//  It supports the opcode set decoded by the single-cycle CONTROL block.
//  The datapath registers IR, MDR, A, B and ALUOut.
// PARAMETERS
//  MEM_TIMEOUT  255  max consecutive cycles a memory request may wait for mem_ready before ERROR
// PORTS
//  clk           in   1  clock
//  rst           in   1  reset; one clock; reset is synchronous and active-high
//  opcode        in   6  IR[31:26] from datapath, sampled in DECODE
//  alu_zero      in   1  ALU zero flag (valid in BRANCH)
//  mem_ready     in   1  memory completes current request this cycle
//  mem_req       out  1  memory request, held until mem_ready
//  mem_we        out  1  write (SW) when mem_req
//  iord          out  1  mem address: 0=PC, 1=ALUOut
//  ir_write      out  1  load IR from mem rdata
//  mdr_write     out  1  load MDR from mem rdata
//  pc_write      out  1  unconditional PC load
//  pc_write_cond out  1  PC load if (alu_zero ^ branch_ne)
//  branch_ne     out  1  1 for BNE
//  pc_src        out  2  0=ALU result, 1=ALUOut, 2=jump target {PC[31:28],IR[25:0],2'b00}
//  alu_src_a     out  1  0=PC, 1=A
//  alu_src_b     out  2  0=B, 1=const 4, 2=sext imm, 3=sext imm<<2
//  alu_op        out  6  0=add, 1=sub, 2=R-type(funct), else the I-type opcode itself
//  reg_write     out  1  register-file write enable
//  reg_dst       out  2  0=rt, 1=rd, 2=$ra(31)
//  wb_sel        out  2  0=ALUOut, 1=MDR, 2=PC
//  err           out  1  sticky error (illegal opcode or timeout)
//  state         out  4  current state, debug
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 BRANCH=5 JUMP=6 ERROR=7.
//  Outputs are Moore: combinational from state plus op_q, the opcode latched at the end of DECODE.
//  Any output not listed for a state is 0.
//  rst: state=FETCH, op_q=0, wait_cnt=0, err=0. All outputs are forced to 0 while rst=1.
//  rst has priority in every state, including a mid-wait memory request: that request is abandoned.
//  FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0.
//    On the mem_ready cycle: ir_write=1, pc_write=1, pc_src=0; next state is DECODE. Otherwise stay.
//  DECODE: latch op_q<=opcode. alu_src_a=0, alu_src_b=3, alu_op=0 (branch target into ALUOut).
//    Next state: BEQ/BNE->BRANCH; J/JAL->JUMP; legal ALU/LW/SW->EXEC; any other opcode->ERROR.
//  EXEC: R-type: alu_src_a=1, alu_src_b=0, alu_op=2.
//    I-type: alu_src_a=1, alu_src_b=2. ADDI, LW and SW use alu_op=0; other I-types use alu_op=op_q.
//    Next state: LW/SW->MEM, else WB.
//  MEM: mem_req=1, iord=1, mem_we=(op_q==SW), mdr_write=(op_q==LW).
//    On mem_ready: LW->WB, SW->FETCH. Otherwise stay.
//  WB: reg_write=1. R-type: reg_dst=1, wb_sel=0. I-ALU: reg_dst=0, wb_sel=0. LW: reg_dst=0, wb_sel=1.
//    Next state is FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_src=1, branch_ne=(op_q==BNE).
//    Next state is FETCH.
//  JUMP: pc_write=1, pc_src=2. JAL also asserts reg_write=1, reg_dst=2, wb_sel=2.
//    PC is already PC+4 here. Next state is FETCH.
//  Cycles at zero wait: R/I-ALU=4, LW=5, SW=4, BEQ/BNE=3, J/JAL=3. Each memory wait adds 1 cycle.
//  Handshake: mem_req, mem_we and iord stay stable from assertion until the mem_ready cycle.
//    mem_ready while mem_req=0 is ignored.
//  wait_cnt counts FETCH/MEM cycles with mem_ready=0 and clears on mem_ready or on leaving the state.
//    When wait_cnt==MEM_TIMEOUT with mem_ready still 0, next state is ERROR.
//    If mem_ready=1 arrives on that same cycle, ready wins.
//  ERROR: all controls 0, err=1. Held until rst.
// TESTING
//  rst for 2 cycles, then release with mem_ready=1 -> mem_req=1 in the first cycle after release, state=0, err=0.
//  R-type (opcode 000000), zero wait -> FETCH,DECODE,EXEC,WB back to FETCH in 4 cycles; WB has reg_write=1, reg_dst=1.
//  LW (100011), 3 wait cycles in MEM -> mem_req/iord=1 stable for 4 cycles, mdr_write=1; then WB with wb_sel=1; total 8 cycles.
//  BNE (000101) with alu_zero=0, then alu_zero=1 -> BRANCH has pc_write_cond=1, branch_ne=1; PC loads only in the first case.
//  JAL (000011) -> JUMP has pc_write=1, pc_src=2, reg_write=1, reg_dst=2, wb_sel=2; next state is FETCH.
//  Opcode 111111, or mem_ready held 0 for MEM_TIMEOUT+1 cycles in FETCH -> ERROR, err=1 sticky; rst mid-wait -> FETCH, err=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM. It sequences fetch, decode, execute, memory
// and write-back over a shared single-port memory with a req/ready handshake.
// All outputs are Moore: they depend only on the current state, the latched
// opcode and, for the FETCH/MEM completion cycle, on mem_ready.
module mips_multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       alu_zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       mdr_write,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       branch_ne,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [5:0] alu_op,
   output logic       reg_write,
   output logic [1:0] reg_dst,
   output logic [1:0] wb_sel,
   output logic       err,
   output logic [3:0] state
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC   = 4'd2,
      S_MEM    = 4'd3,
      S_WB     = 4'd4,
      S_BRANCH = 4'd5,
      S_JUMP   = 4'd6,
      S_ERROR  = 4'd7
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [5:0]       op_q;
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout;

   // I-type ALU group: ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI
   function automatic logic is_ialu(input logic [5:0] op);
      return (op[5:3] == 3'b001);
   endfunction

   function automatic logic is_legal_exec(input logic [5:0] op);
      return (op == OP_RTYPE) || is_ialu(op) || (op == OP_LW) || (op == OP_SW);
   endfunction

   // A memory request has waited its full budget and is still not served;
   // a ready on this same cycle takes precedence.
   assign timeout = (wait_cnt == CNT_W'(MEM_TIMEOUT)) && !mem_ready;

   // State, latched opcode and memory wait counter; rst abandons any pending request
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_FETCH;
         op_q     <= '0;
         wait_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) begin
            op_q <= opcode;
         end
         if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready && (state_d == state_q)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end else begin
            wait_cnt <= '0;
         end
      end
   end

   // Next-state and Moore control decode; everything is held at 0 during rst
   always_comb begin
      state_d       = state_q;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      mdr_write     = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      pc_src        = 2'd0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      alu_op        = 6'd0;
      reg_write     = 1'b0;
      reg_dst       = 2'd0;
      wb_sel        = 2'd0;
      err           = 1'b0;
      state         = state_q;

      case (state_q)
         S_FETCH: begin
            // PC+4 is formed by the ALU while the instruction is read
            mem_req   = 1'b1;
            alu_src_b = 2'd1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (timeout) begin
               state_d = S_ERROR;
            end
         end
         S_DECODE: begin
            // Branch target is computed speculatively into ALUOut
            alu_src_b = 2'd3;
            if (opcode == OP_BEQ || opcode == OP_BNE) begin
               state_d = S_BRANCH;
            end else if (opcode == OP_J || opcode == OP_JAL) begin
               state_d = S_JUMP;
            end else if (is_legal_exec(opcode)) begin
               state_d = S_EXEC;
            end else begin
               state_d = S_ERROR;
            end
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            if (op_q == OP_RTYPE) begin
               alu_src_b = 2'd0;
               alu_op    = 6'd2;
            end else begin
               alu_src_b = 2'd2;
               alu_op    = (op_q == OP_ADDI || op_q == OP_LW || op_q == OP_SW) ? 6'd0 : op_q;
            end
            state_d = (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
         end
         S_MEM: begin
            mem_req   = 1'b1;
            iord      = 1'b1;
            mem_we    = (op_q == OP_SW);
            mdr_write = (op_q == OP_LW);
            if (mem_ready) begin
               state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
            end else if (timeout) begin
               state_d = S_ERROR;
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            reg_dst   = (op_q == OP_RTYPE) ? 2'd1 : 2'd0;
            wb_sel    = (op_q == OP_LW) ? 2'd1 : 2'd0;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_src_b     = 2'd0;
            alu_op        = 6'd1;
            pc_write_cond = 1'b1;
            pc_src        = 2'd1;
            branch_ne     = (op_q == OP_BNE);
            state_d       = S_FETCH;
         end
         S_JUMP: begin
            // PC already holds PC+4, which is the JAL link value
            pc_write = 1'b1;
            pc_src   = 2'd2;
            if (op_q == OP_JAL) begin
               reg_write = 1'b1;
               reg_dst   = 2'd2;
               wb_sel    = 2'd2;
            end
            state_d = S_FETCH;
         end
         S_ERROR: begin
            err = 1'b1;
         end
         default: begin
            state_d = S_ERROR;
         end
      endcase

      if (rst) begin
         mem_req       = 1'b0;
         mem_we        = 1'b0;
         iord          = 1'b0;
         ir_write      = 1'b0;
         mdr_write     = 1'b0;
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         branch_ne     = 1'b0;
         pc_src        = 2'd0;
         alu_src_a     = 1'b0;
         alu_src_b     = 2'd0;
         alu_op        = 6'd0;
         reg_write     = 1'b0;
         reg_dst       = 2'd0;
         wb_sel        = 2'd0;
         err           = 1'b0;
         state         = 4'd0;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-cycle stimulus tables,
// expected control words queued at drive time and popped at the falling edge.
module tb_mips_multicycle_ctrl;

   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_J   = 6'h02;
   localparam logic [5:0] OP_JAL = 6'h03;
   localparam logic [5:0] OP_BNE = 6'h05;
   localparam logic [5:0] OP_ADDI= 6'h08;
   localparam logic [5:0] OP_ORI = 6'h0D;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2B;
   localparam logic [5:0] OP_BAD = 6'h3F;

   typedef struct packed {
      logic [3:0] st;
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_write;
      logic       mdr_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [5:0] alu_op;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] wb_sel;
      logic       err;
   } ctl_t;

   typedef struct packed {
      logic       rst;
      logic       rdy;
      logic       zero;
      logic [5:0] op;
      ctl_t       e;
   } step_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = '0;
   logic       alu_zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_write_cond, branch_ne;
   logic [1:0] pc_src, alu_src_b, reg_dst, wb_sel;
   logic       alu_src_a, reg_write, err;
   logic [5:0] alu_op;
   logic [3:0] state;
   ctl_t       obs;

   int tests  = 0;
   int failed = 0;
   ctl_t sb[$];

   always #5 clk = ~clk;

   mips_multicycle_ctrl #(.MEM_TIMEOUT(255)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
      .mdr_write(mdr_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .branch_ne(branch_ne), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst), .wb_sel(wb_sel),
      .err(err), .state(state)
   );

   assign obs = {state, mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_write_cond,
                 branch_ne, pc_src, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, wb_sel, err};

   // Expected control words, one per state, written from the state tables
   function automatic ctl_t e_zero();
      ctl_t c = '0;
      return c;
   endfunction
   function automatic ctl_t e_fetch(input logic rdy);
      ctl_t c = '0;
      c.st = 4'd0; c.mem_req = 1'b1; c.alu_src_b = 2'd1;
      if (rdy) begin c.ir_write = 1'b1; c.pc_write = 1'b1; end
      return c;
   endfunction
   function automatic ctl_t e_decode();
      ctl_t c = '0;
      c.st = 4'd1; c.alu_src_b = 2'd3;
      return c;
   endfunction
   function automatic ctl_t e_exec(input logic [5:0] op);
      ctl_t c = '0;
      c.st = 4'd2; c.alu_src_a = 1'b1;
      if (op == OP_R) begin c.alu_src_b = 2'd0; c.alu_op = 6'd2; end
      else begin
         c.alu_src_b = 2'd2;
         c.alu_op = (op == OP_ADDI || op == OP_LW || op == OP_SW) ? 6'd0 : op;
      end
      return c;
   endfunction
   function automatic ctl_t e_mem(input logic [5:0] op);
      ctl_t c = '0;
      c.st = 4'd3; c.mem_req = 1'b1; c.iord = 1'b1;
      c.mem_we = (op == OP_SW); c.mdr_write = (op == OP_LW);
      return c;
   endfunction
   function automatic ctl_t e_wb(input logic [5:0] op);
      ctl_t c = '0;
      c.st = 4'd4; c.reg_write = 1'b1;
      c.reg_dst = (op == OP_R) ? 2'd1 : 2'd0;
      c.wb_sel  = (op == OP_LW) ? 2'd1 : 2'd0;
      return c;
   endfunction
   function automatic ctl_t e_branch(input logic [5:0] op);
      ctl_t c = '0;
      c.st = 4'd5; c.alu_src_a = 1'b1; c.alu_op = 6'd1; c.pc_write_cond = 1'b1;
      c.pc_src = 2'd1; c.branch_ne = (op == OP_BNE);
      return c;
   endfunction
   function automatic ctl_t e_jump(input logic [5:0] op);
      ctl_t c = '0;
      c.st = 4'd6; c.pc_write = 1'b1; c.pc_src = 2'd2;
      if (op == OP_JAL) begin c.reg_write = 1'b1; c.reg_dst = 2'd2; c.wb_sel = 2'd2; end
      return c;
   endfunction
   function automatic ctl_t e_error();
      ctl_t c = '0;
      c.st = 4'd7; c.err = 1'b1;
      return c;
   endfunction

   function automatic step_t mk(input logic r, input logic rdy, input logic z,
                                input logic [5:0] op, input ctl_t e);
      step_t s;
      s.rst = r; s.rdy = rdy; s.zero = z; s.op = op; s.e = e;
      return s;
   endfunction

   task automatic test_reset();
      step_t s[$];
      ctl_t  ex;
      s.push_back(mk(1, 1, 0, OP_R, e_zero()));
      s.push_back(mk(1, 1, 0, OP_R, e_zero()));
      s.push_back(mk(0, 1, 0, OP_R, e_fetch(1)));
      foreach (s[i]) begin
         rst = s[i].rst; mem_ready = s[i].rdy; alu_zero = s[i].zero; opcode = s[i].op;
         sb.push_back(s[i].e);
         @(negedge clk);
         ex = sb.pop_front();
         tests++;
         if (obs !== ex) begin
            failed++;
            $display("FAIL reset[%0d]: got state=%0d ctl=%h, expected state=%0d ctl=%h", i, obs.st, obs, ex.st, ex);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_rtype();
      step_t s[$];
      ctl_t  ex;
      s.push_back(mk(1, 0, 0, OP_R, e_zero()));
      s.push_back(mk(1, 0, 0, OP_R, e_zero()));
      s.push_back(mk(0, 1, 0, OP_R, e_fetch(1)));
      s.push_back(mk(0, 0, 0, OP_R, e_decode()));
      s.push_back(mk(0, 0, 0, OP_R, e_exec(OP_R)));
      s.push_back(mk(0, 0, 0, OP_R, e_wb(OP_R)));
      s.push_back(mk(0, 0, 0, OP_R, e_fetch(0)));
      foreach (s[i]) begin
         rst = s[i].rst; mem_ready = s[i].rdy; alu_zero = s[i].zero; opcode = s[i].op;
         sb.push_back(s[i].e);
         @(negedge clk);
         ex = sb.pop_front();
         tests++;
         if (obs !== ex) begin
            failed++;
            $display("FAIL rtype[%0d]: got state=%0d ctl=%h, expected state=%0d ctl=%h", i, obs.st, obs, ex.st, ex);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_lw_wait();
      step_t s[$];
      ctl_t  ex;
      s.push_back(mk(1, 0, 0, OP_LW, e_zero()));
      s.push_back(mk(1, 0, 0, OP_LW, e_zero()));
      s.push_back(mk(0, 1, 0, OP_LW, e_fetch(1)));
      s.push_back(mk(0, 0, 0, OP_LW, e_decode()));
      s.push_back(mk(0, 1, 0, OP_LW, e_exec(OP_LW)));
      for (int k = 0; k < 3; k++) s.push_back(mk(0, 0, 0, OP_LW, e_mem(OP_LW)));
      s.push_back(mk(0, 1, 0, OP_LW, e_mem(OP_LW)));
      s.push_back(mk(0, 1, 0, OP_LW, e_wb(OP_LW)));
      s.push_back(mk(0, 0, 0, OP_LW, e_fetch(0)));
      foreach (s[i]) begin
         rst = s[i].rst; mem_ready = s[i].rdy; alu_zero = s[i].zero; opcode = s[i].op;
         sb.push_back(s[i].e);
         @(negedge clk);
         ex = sb.pop_front();
         tests++;
         if (obs !== ex) begin
            failed++;
            $display("FAIL lw_wait[%0d]: got state=%0d ctl=%h, expected state=%0d ctl=%h", i, obs.st, obs, ex.st, ex);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_bne();
      step_t s[$];
      bit    ld_exp[$];
      ctl_t  ex;
      bit    le;
      logic  ld;
      s.push_back(mk(1, 0, 0, OP_BNE, e_zero()));           ld_exp.push_back(0);
      s.push_back(mk(1, 0, 0, OP_BNE, e_zero()));           ld_exp.push_back(0);
      s.push_back(mk(0, 1, 0, OP_BNE, e_fetch(1)));         ld_exp.push_back(1);
      s.push_back(mk(0, 0, 0, OP_BNE, e_decode()));         ld_exp.push_back(0);
      s.push_back(mk(0, 0, 0, OP_BNE, e_branch(OP_BNE)));   ld_exp.push_back(1);
      s.push_back(mk(0, 1, 1, OP_BNE, e_fetch(1)));         ld_exp.push_back(1);
      s.push_back(mk(0, 0, 1, OP_BNE, e_decode()));         ld_exp.push_back(0);
      s.push_back(mk(0, 0, 1, OP_BNE, e_branch(OP_BNE)));   ld_exp.push_back(0);
      s.push_back(mk(0, 0, 0, OP_BNE, e_fetch(0)));         ld_exp.push_back(0);
      foreach (s[i]) begin
         rst = s[i].rst; mem_ready = s[i].rdy; alu_zero = s[i].zero; opcode = s[i].op;
         sb.push_back(s[i].e);
         @(negedge clk);
         ex = sb.pop_front();
         le = ld_exp.pop_front();
         tests++;
         if (obs !== ex) begin
            failed++;
            $display("FAIL bne[%0d]: got state=%0d ctl=%h, expected state=%0d ctl=%h", i, obs.st, obs, ex.st, ex);
         end
         ld = pc_write | (pc_write_cond & (alu_zero ^ branch_ne));
         tests++;
         if (ld !== le) begin
            failed++;
            $display("FAIL bne_pc_load[%0d]: got %b, expected %b", i, ld, le);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_jal();
      step_t s[$];
      ctl_t  ex;
      s.push_back(mk(1, 0, 0, OP_JAL, e_zero()));
      s.push_back(mk(1, 0, 0, OP_JAL, e_zero()));
      s.push_back(mk(0, 1, 0, OP_JAL, e_fetch(1)));
      s.push_back(mk(0, 0, 0, OP_JAL, e_decode()));
      s.push_back(mk(0, 0, 0, OP_JAL, e_jump(OP_JAL)));
      s.push_back(mk(0, 0, 0, OP_JAL, e_fetch(0)));
      foreach (s[i]) begin
         rst = s[i].rst; mem_ready = s[i].rdy; alu_zero = s[i].zero; opcode = s[i].op;
         sb.push_back(s[i].e);
         @(negedge clk);
         ex = sb.pop_front();
         tests++;
         if (obs !== ex) begin
            failed++;
            $display("FAIL jal[%0d]: got state=%0d ctl=%h, expected state=%0d ctl=%h", i, obs.st, obs, ex.st, ex);
         end
         @(posedge clk); #1;
      end
   endtask

   // SW with an immediate ready, then J, ADDI and ORI issued without gaps
   task automatic test_back_to_back();
      step_t s[$];
      ctl_t  ex;
      s.push_back(mk(1, 0, 0, OP_SW, e_zero()));
      s.push_back(mk(1, 0, 0, OP_SW, e_zero()));
      s.push_back(mk(0, 1, 0, OP_SW, e_fetch(1)));
      s.push_back(mk(0, 0, 0, OP_SW, e_decode()));
      s.push_back(mk(0, 0, 0, OP_SW, e_exec(OP_SW)));
      s.push_back(mk(0, 1, 0, OP_SW, e_mem(OP_SW)));
      s.push_back(mk(0, 1, 0, OP_J, e_fetch(1)));
      s.push_back(mk(0, 0, 0, OP_J, e_decode()));
      s.push_back(mk(0, 0, 0, OP_J, e_jump(OP_J)));
      s.push_back(mk(0, 1, 0, OP_ADDI, e_fetch(1)));
      s.push_back(mk(0, 0, 0, OP_ADDI, e_decode()));
      s.push_back(mk(0, 0, 0, OP_ADDI, e_exec(OP_ADDI)));
      s.push_back(mk(0, 0, 0, OP_ADDI, e_wb(OP_ADDI)));
      s.push_back(mk(0, 1, 0, OP_ORI, e_fetch(1)));
      s.push_back(mk(0, 0, 0, OP_ORI, e_decode()));
      s.push_back(mk(0, 0, 0, OP_R, e_exec(OP_ORI)));
      s.push_back(mk(0, 0, 0, OP_R, e_wb(OP_ORI)));
      s.push_back(mk(0, 0, 0, OP_R, e_fetch(0)));
      foreach (s[i]) begin
         rst = s[i].rst; mem_ready = s[i].rdy; alu_zero = s[i].zero; opcode = s[i].op;
         sb.push_back(s[i].e);
         @(negedge clk);
         ex = sb.pop_front();
         tests++;
         if (obs !== ex) begin
            failed++;
            $display("FAIL back_to_back[%0d]: got state=%0d ctl=%h, expected state=%0d ctl=%h", i, obs.st, obs, ex.st, ex);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal();
      step_t s[$];
      ctl_t  ex;
      s.push_back(mk(1, 0, 0, OP_BAD, e_zero()));
      s.push_back(mk(1, 0, 0, OP_BAD, e_zero()));
      s.push_back(mk(0, 1, 0, OP_BAD, e_fetch(1)));
      s.push_back(mk(0, 0, 0, OP_BAD, e_decode()));
      for (int k = 0; k < 3; k++) s.push_back(mk(0, 1, 0, OP_R, e_error()));
      s.push_back(mk(1, 0, 0, OP_R, e_zero()));
      s.push_back(mk(0, 0, 0, OP_R, e_fetch(0)));
      foreach (s[i]) begin
         rst = s[i].rst; mem_ready = s[i].rdy; alu_zero = s[i].zero; opcode = s[i].op;
         sb.push_back(s[i].e);
         @(negedge clk);
         ex = sb.pop_front();
         tests++;
         if (obs !== ex) begin
            failed++;
            $display("FAIL illegal[%0d]: got state=%0d ctl=%h, expected state=%0d ctl=%h", i, obs.st, obs, ex.st, ex);
         end
         @(posedge clk); #1;
      end
   endtask

   // 256 unserved FETCH cycles time out; rst mid-wait clears the counter,
   // and a ready on the final allowed cycle wins over the timeout.
   task automatic test_timeout();
      step_t s[$];
      ctl_t  ex;
      s.push_back(mk(1, 0, 0, OP_R, e_zero()));
      s.push_back(mk(1, 0, 0, OP_R, e_zero()));
      for (int k = 0; k < 256; k++) s.push_back(mk(0, 0, 0, OP_R, e_fetch(0)));
      s.push_back(mk(0, 1, 0, OP_R, e_error()));
      s.push_back(mk(0, 0, 0, OP_R, e_error()));
      s.push_back(mk(1, 0, 0, OP_R, e_zero()));
      for (int k = 0; k < 100; k++) s.push_back(mk(0, 0, 0, OP_R, e_fetch(0)));
      s.push_back(mk(1, 0, 0, OP_R, e_zero()));
      for (int k = 0; k < 255; k++) s.push_back(mk(0, 0, 0, OP_R, e_fetch(0)));
      s.push_back(mk(0, 1, 0, OP_R, e_fetch(1)));
      s.push_back(mk(0, 0, 0, OP_R, e_decode()));
      foreach (s[i]) begin
         rst = s[i].rst; mem_ready = s[i].rdy; alu_zero = s[i].zero; opcode = s[i].op;
         sb.push_back(s[i].e);
         @(negedge clk);
         ex = sb.pop_front();
         tests++;
         if (obs !== ex) begin
            failed++;
            $display("FAIL timeout[%0d]: got state=%0d ctl=%h, expected state=%0d ctl=%h", i, obs.st, obs, ex.st, ex);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_rtype();
      test_lw_wait();
      test_bne();
      test_jal();
      test_back_to_back();
      test_illegal();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
